// File: rtl/cache_pkg.sv
// Shared types and constants for the cache-to-DRAM miss path.
package cache_pkg;
  localparam int BLK_AW      = 23;
  localparam int LINE_DW     = 128;
  localparam int TIMEOUT_DEF = 1024;

  typedef enum logic [2:0] {IDLE, WB, RD, DONE, ERR} mem_state_e;

  typedef logic [BLK_AW-1:0]  blk_addr_t;
  typedef logic [LINE_DW-1:0] line_t;
endpackage

// File: rtl/cache_mem_ctrl_if.sv
// Miss request / refill handshake plus DRAM strobe bus; slave is the controller side.
interface cache_mem_ctrl_if;
  import cache_pkg::*;

  logic      req_valid;
  logic      req_ready;
  logic      req_dirty;
  blk_addr_t req_victim_addr;
  line_t     req_victim_data;
  blk_addr_t req_refill_addr;
  logic      refill_valid;
  line_t     refill_data;
  logic      err_timeout;
  logic      mem_wren;
  logic      mem_rden;
  blk_addr_t mem_addr;
  line_t     mem_wdata;
  line_t     mem_rdata;
  logic      mem_ready;

  modport slave (
    input  req_valid, req_dirty, req_victim_addr, req_victim_data, req_refill_addr,
    input  mem_rdata, mem_ready,
    output req_ready, refill_valid, refill_data, err_timeout,
    output mem_wren, mem_rden, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_dirty, req_victim_addr, req_victim_data, req_refill_addr,
    output mem_rdata, mem_ready,
    input  req_ready, refill_valid, refill_data, err_timeout,
    input  mem_wren, mem_rden, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_watchdog.sv
// Saturating wait counter; expire is high once the count sits at TIMEOUT-1.
module mem_watchdog #(
  parameter int TIMEOUT = cache_pkg::TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);
  localparam int            CW    = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = (r_cnt == LIMIT);
endmodule

// File: rtl/cache_mem_ctrl.sv
// Miss handler: optional victim write-back, then refill read, one-cycle refill pulse.
// Strobes decode straight from state so an async reset drops them at once.
module cache_mem_ctrl
  import cache_pkg::*;
#(
  parameter int AWIDTH  = BLK_AW,
  parameter int DWIDTH  = LINE_DW,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  cache_mem_ctrl_if.slave  bus
);
  mem_state_e        r_state;
  mem_state_e        w_state_nxt;
  logic [AWIDTH-1:0] r_refill_addr;
  logic [AWIDTH-1:0] r_mem_addr;
  logic [DWIDTH-1:0] r_mem_wdata;
  logic [DWIDTH-1:0] r_refill_data;
  logic              w_accept;
  logic              w_wd_clr;
  logic              w_wd_en;
  logic              w_wd_expire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Watchdog is cleared on every entry into WB or RD, so each phase gets its own budget.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_wd_clr    = 1'b0;
    w_wd_en     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          w_accept    = 1'b1;
          w_wd_clr    = 1'b1;
          w_state_nxt = bus.req_dirty ? WB : RD;
        end
      end
      WB: begin
        if (bus.mem_ready) begin
          w_wd_clr    = 1'b1;
          w_state_nxt = RD;
        end else begin
          w_wd_en = 1'b1;
          if (w_wd_expire) w_state_nxt = ERR;
        end
      end
      RD: begin
        if (bus.mem_ready) begin
          w_state_nxt = DONE;
        end else begin
          w_wd_en = 1'b1;
          if (w_wd_expire) w_state_nxt = ERR;
        end
      end
      DONE:    w_state_nxt = IDLE;
      ERR:     w_state_nxt = ERR;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_refill_addr <= '0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_refill_data <= '0;
    end else begin
      if (w_accept) begin
        r_refill_addr <= bus.req_refill_addr;
        r_mem_addr    <= bus.req_dirty ? bus.req_victim_addr : bus.req_refill_addr;
        if (bus.req_dirty) r_mem_wdata <= bus.req_victim_data;
      end
      if ((r_state == WB) && bus.mem_ready) r_mem_addr    <= r_refill_addr;
      if ((r_state == RD) && bus.mem_ready) r_refill_data <= bus.mem_rdata;
    end
  end

  mem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_wd_clr),
    .i_en     (w_wd_en),
    .o_expire (w_wd_expire)
  );

  // ERR is terminal until reset, so the sticky error flag is simply the state.
  assign bus.req_ready    = (r_state == IDLE);
  assign bus.refill_valid = (r_state == DONE);
  assign bus.err_timeout  = (r_state == ERR);
  assign bus.mem_wren     = (r_state == WB);
  assign bus.mem_rden     = (r_state == RD);
  assign bus.mem_addr     = r_mem_addr;
  assign bus.mem_wdata    = r_mem_wdata;
  assign bus.refill_data  = r_refill_data;
endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Directed bench for cache_mem_ctrl: drives and samples on the falling edge, acts as cache and DRAM.
module tb_cache_mem_ctrl;
  localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] D2 = 128'hDEADBEEF00112233CAFEF00D44556677;
  localparam logic [127:0] DA = {8{16'hAAAA}};
  localparam logic [127:0] D5 = {8{16'h5555}};

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_err = 0;
  int   n_chk = 0;
  logic [127:0] tbmem [logic [22:0]];
  logic [127:0] mem_word;

  cache_mem_ctrl_if bus ();

  cache_mem_ctrl #(.AWIDTH(23), .DWIDTH(128), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL sim_budget: bench did not reach its summary line");
    $fatal(1, "time limit");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents a request for one edge, then scrambles the request inputs.
  task automatic issue(input bit dirty, input logic [22:0] va, input logic [127:0] vd,
                       input logic [22:0] ra);
    chk("req_ready_idle", bus.req_ready, 1'b1);
    bus.req_valid       = 1'b1;
    bus.req_dirty       = dirty;
    bus.req_victim_addr = va;
    bus.req_victim_data = vd;
    bus.req_refill_addr = ra;
    step();
    bus.req_valid       = 1'b0;
    bus.req_dirty       = ~dirty;
    bus.req_victim_addr = ~va;
    bus.req_victim_data = ~vd;
    bus.req_refill_addr = ~ra;
  endtask

  // DRAM side of one transfer: strobe is checked for lat+1 cycles, ready given on the last.
  task automatic dram_phase(input bit is_wr, input int lat, input logic [22:0] exp_addr,
                            input logic [127:0] exp_wdat, input bit toggle);
    for (int i = 0; i <= lat; i++) begin
      chk("mem_wren", bus.mem_wren, is_wr);
      chk("mem_rden", bus.mem_rden, !is_wr);
      chk("mem_addr", bus.mem_addr, exp_addr);
      if (is_wr) chk("mem_wdata", bus.mem_wdata, exp_wdat);
      chk("req_ready_busy", bus.req_ready, 1'b0);
      chk("refill_valid_busy", bus.refill_valid, 1'b0);
      chk("err_busy", bus.err_timeout, 1'b0);
      if (toggle) begin
        bus.req_valid       = 1'($urandom);
        bus.req_dirty       = 1'($urandom);
        bus.req_victim_addr = 23'($urandom);
        bus.req_victim_data = {4{$urandom}};
        bus.req_refill_addr = 23'($urandom);
      end
      if (i == lat) begin
        bus.mem_ready = 1'b1;
        if (is_wr) tbmem[bus.mem_addr] = bus.mem_wdata;
        else bus.mem_rdata = tbmem.exists(bus.mem_addr) ? tbmem[bus.mem_addr] : '0;
      end
      step();
    end
    bus.mem_ready = 1'b0;
    bus.mem_rdata = {4{$urandom}};
  endtask

  task automatic finish_refill(input logic [127:0] exp_data);
    chk("refill_valid", bus.refill_valid, 1'b1);
    chk("refill_data", bus.refill_data, exp_data);
    chk("wren_done", bus.mem_wren, 1'b0);
    chk("rden_done", bus.mem_rden, 1'b0);
    step();
    chk("refill_pulse_end", bus.refill_valid, 1'b0);
    chk("refill_data_hold", bus.refill_data, exp_data);
  endtask

  initial begin
    bus.req_valid       = 1'b0;
    bus.req_dirty       = 1'b0;
    bus.req_victim_addr = '0;
    bus.req_victim_data = '0;
    bus.req_refill_addr = '0;
    bus.mem_rdata       = '0;
    bus.mem_ready       = 1'b0;
    tbmem[23'h10] = D1;
    tbmem[23'h30] = D2;

    #3;
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_wren", bus.mem_wren, 1'b0);
    chk("rst_rden", bus.mem_rden, 1'b0);
    chk("rst_addr", bus.mem_addr, 23'h0);
    chk("rst_wdata", bus.mem_wdata, 128'h0);
    chk("rst_refill_data", bus.refill_data, 128'h0);
    chk("rst_refill_valid", bus.refill_valid, 1'b0);
    chk("rst_err", bus.err_timeout, 1'b0);
    step();
    rst = 1'b1;
    step();

    // clean miss, one-cycle DRAM latency
    issue(1'b0, 23'h7, D5, 23'h10);
    dram_phase(1'b0, 1, 23'h10, '0, 1'b0);
    finish_refill(D1);

    // dirty miss: write-back 0x20 then refill 0x30
    issue(1'b1, 23'h20, DA, 23'h30);
    dram_phase(1'b1, 1, 23'h20, DA, 1'b0);
    dram_phase(1'b0, 1, 23'h30, '0, 1'b0);
    finish_refill(D2);

    // written-back victim reads back
    issue(1'b0, 23'h0, '0, 23'h20);
    dram_phase(1'b0, 1, 23'h20, '0, 1'b0);
    finish_refill(DA);

    // slow DRAM; read phase waits right up to the watchdog limit
    issue(1'b1, 23'h40, D5, 23'h10);
    dram_phase(1'b1, 7, 23'h40, D5, 1'b0);
    dram_phase(1'b0, 15, 23'h10, '0, 1'b0);
    finish_refill(D1);
    mem_word = tbmem.exists(23'h40) ? tbmem[23'h40] : '0;
    chk("wb_slow_stored", mem_word, D5);

    // request inputs churn during RD
    issue(1'b0, 23'h0, '0, 23'h30);
    dram_phase(1'b0, 3, 23'h30, '0, 1'b1);
    bus.req_valid = 1'b0;
    finish_refill(D2);
    chk("req_ready_after_done", bus.req_ready, 1'b1);

    // DRAM never answers
    issue(1'b0, 23'h0, '0, 23'h50);
    for (int i = 0; i < 16; i++) begin
      chk("to_rden", bus.mem_rden, 1'b1);
      chk("to_err_early", bus.err_timeout, 1'b0);
      step();
    end
    chk("to_err", bus.err_timeout, 1'b1);
    chk("to_rden_off", bus.mem_rden, 1'b0);
    chk("to_wren_off", bus.mem_wren, 1'b0);
    chk("to_req_ready", bus.req_ready, 1'b0);
    chk("to_refill_valid", bus.refill_valid, 1'b0);
    bus.req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("err_hold_req_ready", bus.req_ready, 1'b0);
      chk("err_hold_flag", bus.err_timeout, 1'b1);
      chk("err_hold_refill", bus.refill_valid, 1'b0);
      chk("err_hold_rden", bus.mem_rden, 1'b0);
    end
    bus.req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("err_reset_flag", bus.err_timeout, 1'b0);
    chk("err_reset_ready", bus.req_ready, 1'b1);
    step();
    rst = 1'b1;
    step();

    // reset in the middle of a write-back
    issue(1'b1, 23'h60, DA, 23'h10);
    chk("mid_wb_wren", bus.mem_wren, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_wren", bus.mem_wren, 1'b0);
    chk("mid_rst_rden", bus.mem_rden, 1'b0);
    chk("mid_rst_addr", bus.mem_addr, 23'h0);
    chk("mid_rst_wdata", bus.mem_wdata, 128'h0);
    chk("mid_rst_refill_data", bus.refill_data, 128'h0);
    chk("mid_rst_refill_valid", bus.refill_valid, 1'b0);
    chk("mid_rst_req_ready", bus.req_ready, 1'b1);
    chk("mid_rst_err", bus.err_timeout, 1'b0);
    step();
    rst = 1'b1;
    step();
    issue(1'b0, 23'h0, '0, 23'h30);
    dram_phase(1'b0, 1, 23'h30, '0, 1'b0);
    finish_refill(D2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/cache_mem_ctrl.md
# cache_mem_ctrl

Block-level DRAM initiator between the data cache controller and the `dram` memory model. On a cache miss it writes back the dirty victim block (if any), then fetches the refill block. It drives the DRAM wren/rden/addr/data_in strobes, waits for `mem_ready`, and returns the 128-bit refill line to the cache with a one-cycle valid pulse. A watchdog flags a DRAM that never responds.

## Interface
Parameters:
- AWIDTH, 23, block address width (byte address >> 4)
- DWIDTH, 128, cache line width
- TIMEOUT, 1024, max cycles waiting for `mem_ready` before error

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  miss request from cache controller
- req_ready  out  1  high only in IDLE
- req_dirty  in  1  victim must be written back
- req_victim_addr  in  AWIDTH  victim block address
- req_victim_data  in  DWIDTH  victim line
- req_refill_addr  in  AWIDTH  missing block address
- refill_valid  out  1  one-cycle pulse, refill_data valid
- refill_data  out  DWIDTH  fetched line, held until next capture
- err_timeout  out  1  sticky, set on watchdog expiry
- mem_wren  out  1  DRAM write strobe
- mem_rden  out  1  DRAM read strobe
- mem_addr  out  AWIDTH  DRAM block address
- mem_wdata  out  DWIDTH  DRAM write data
- mem_rdata  in  DWIDTH  DRAM read data
- mem_ready  in  1  DRAM transfer complete

## Operation
- States: IDLE, WB, RD, DONE, ERR.
- IDLE: req_ready=1. On req_valid, latch victim addr/data, refill addr, and dirty. Go to WB if dirty, else RD.
- WB: mem_wren=1, mem_addr=victim addr, mem_wdata=victim data.
  - On mem_ready → RD.
- RD: mem_rden=1, mem_addr=refill addr.
  - On mem_ready, capture mem_rdata into refill_data → DONE.
- DONE: refill_valid=1 for exactly one cycle → IDLE.
- mem_wren and mem_rden are never high in the same cycle.
- Strobes, addr, and wdata are held stable for the whole WB/RD wait.
- Request inputs are ignored outside IDLE. Latched copies are used, so the cache may change its inputs after acceptance.
- mem_ready is ignored in IDLE, DONE, and ERR.
- Watchdog:
  - Counter cleared on every entry to WB or RD, and increments each cycle in WB/RD without mem_ready.
  - When the count reaches TIMEOUT-1 with no mem_ready: set err_timeout, drop strobes, go to ERR.
  - ERR holds req_ready=0 until reset; no refill_valid is produced.
- Counter width is $clog2(TIMEOUT)+1. The count saturates and does not wrap.

## Timing
- Reset (rst=0, async): state=IDLE, all strobes 0, mem_addr=0, mem_wdata=0, refill_data=0, refill_valid=0, err_timeout=0, counter=0.
- Acceptance at edge N: the strobe is high from cycle N+1.
- mem_ready sampled high at edge M:
  - Strobe is low, or switched wren→rden, from cycle M+1.
  - For a read, refill_data is valid and refill_valid=1 during cycle M+1.
- Clean miss, mem_ready 1 cycle after rden: accept N, rden N+1, ready at N+2, refill_valid N+3. Total 3 cycles.
- Dirty miss, same DRAM latency: refill_valid at N+5.
- Back-to-back: req_ready returns in the cycle after DONE. Minimum request spacing is 4 cycles (clean).
- mem_ready already high on the first WB/RD cycle: the transfer completes that edge. No minimum strobe width beyond 1 cycle.
- Reset mid-transfer: strobes drop immediately (async), and the latched request is discarded.

## Structure
- Shared package `cache_pkg`:
  - `mem_state_e` enum (IDLE, WB, RD, DONE, ERR)
  - `blk_addr_t` (logic [AWIDTH-1:0])
  - `line_t` (logic [DWIDTH-1:0])
  - default TIMEOUT constant
- One sub-module, `mem_watchdog`: saturating counter with clear/enable inputs and an expire output. The FSM and datapath registers stay in `cache_mem_ctrl`.

## Test plan
- Clean miss: refill_addr=0x000010, DRAM preloaded 0x0123…CDEF, ready 1 cycle after rden. Required: no wren, single rden, refill_data=0x0123…CDEF, refill_valid exactly one cycle, 3 cycles after acceptance.
- Dirty miss: victim 0x000020 / data 0xAAAA…AAAA, refill 0x000030.
  - Required: wren with addr 0x20 precedes rden with addr 0x30, and they never overlap.
  - Re-reading 0x20 afterwards returns 0xAAAA…AAAA.
- Slow DRAM: mem_ready delayed 7 cycles. Required: strobe, addr, and wdata are stable for all 7 cycles, then one refill_valid.
- Input change after accept: toggle req_* and req_valid during RD. Required: no effect, req_ready=0 until after DONE.
- Timeout: TIMEOUT=16, mem_ready held low. Required: err_timeout=1 after 16 RD cycles, strobes 0, req_ready stays 0, no refill_valid.
- Reset mid-WB: assert rst during wren. Required: all outputs go to reset values in the same cycle, and a fresh request after release completes normally.
